// File: rtl/ternary_mac_array.sv
// ROWS x COLS ternary-weight MAC array with double-buffered snapshot and byte readout.
// Optional: define TERNARY_MAC_ROUND_EN for round-half-up before the readout shift.
module ternary_mac_array #(
  parameter int ROWS  = 4,
  parameter int COLS  = 2,
  parameter int IN_W  = 8,
  parameter int ACC_W = 17,
  localparam int N     = ROWS * COLS,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [2*ROWS-1:0]      in_weights,
  input  logic [COLS*IN_W-1:0]   in_acts,
  input  logic                   read_start,
  input  logic [3:0]             shift,
  input  logic                   relu,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   read_busy,
  output logic                   dbg_state,
  output logic [IDX_W-1:0]       dbg_idx
);

  // Handshake: an element transfers on a rising edge where out_valid && out_ready;
  // out_data/out_last are stable while out_valid is high and out_ready is low.

  typedef enum logic {IDLE, STREAM} state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;

  logic                      valid_q, start_q, relu_q, relu_l_q;
  logic [2*ROWS-1:0]         weights_q;
  logic [COLS*IN_W-1:0]      acts_q;
  logic [3:0]                shift_q, shift_l_q;

  logic signed [ACC_W-1:0]   acc_q   [N];
  logic signed [ACC_W-1:0]   acc_d   [N];
  logic signed [ACC_W-1:0]   queue_q [N];
  logic signed [ACC_W-1:0]   x_ext;
  logic [1:0]                w_sel;

  logic                      snapshot;
  logic signed [ACC_W-1:0]   q_sel;
  logic signed [ACC_W:0]     pp_v, pp_s;
  logic [7:0]                pp_sat;

  assign snapshot = start_q && (state_q == IDLE);

  always_comb begin
    x_ext = '0;
    w_sel = '0;
    for (int i = 0; i < N; i++) begin
      acc_d[i] = acc_q[i];
      w_sel    = weights_q[2*(i/COLS) +: 2];
      x_ext    = ACC_W'(signed'(acts_q[(i%COLS)*IN_W +: IN_W]));
      if (valid_q) begin
        if (w_sel == 2'b01) acc_d[i] = acc_q[i] + x_ext;
        else if (w_sel[1])  acc_d[i] = acc_q[i] - x_ext;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start_q) begin
          state_d = STREAM;
          idx_d   = '0;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (idx_q == IDX_W'(N - 1)) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      weights_q <= '0;
      acts_q    <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      shift_l_q <= '0;
      relu_l_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        acc_q[i]   <= '0;
        queue_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      valid_q   <= in_valid;
      start_q   <= read_start;
      weights_q <= in_weights;
      acts_q    <= in_acts;
      shift_q   <= shift;
      relu_q    <= relu;
      if (snapshot) begin
        shift_l_q <= shift_q;
        relu_l_q  <= relu_q;
      end
      // The sample arriving alongside read_start lands in the snapshot, not the fresh accumulators.
      for (int i = 0; i < N; i++) begin
        if (snapshot) begin
          queue_q[i] <= acc_d[i];
          acc_q[i]   <= '0;
        end else begin
          acc_q[i] <= acc_d[i];
        end
      end
    end
  end

  always_comb begin
    q_sel = queue_q[idx_q];
    pp_v  = {q_sel[ACC_W-1], q_sel};
    if (relu_l_q && q_sel[ACC_W-1]) pp_v = '0;
`ifdef TERNARY_MAC_ROUND_EN
    if (shift_l_q != 4'd0) pp_v = pp_v + ((ACC_W+1)'(1) << (shift_l_q - 4'd1));
`else
`endif
    pp_s = pp_v >>> shift_l_q;
    if (pp_s > (ACC_W+1)'(127))       pp_sat = 8'h7f;
    else if (pp_s < (ACC_W+1)'(-128)) pp_sat = 8'h80;
    else                              pp_sat = pp_s[7:0];
  end

  assign out_valid = (state_q == STREAM);
  assign read_busy = (state_q == STREAM);
  assign out_last  = (state_q == STREAM) && (idx_q == IDX_W'(N - 1));
  assign out_data  = (state_q == STREAM) ? pp_sat : 8'h00;
  assign dbg_state = (state_q == STREAM);
  assign dbg_idx   = idx_q;

endmodule

// File: doc/ternary_mac_array.md
Name: ternary_mac_array

Overview:
- Parametrised ROWS x COLS systolic multiply-accumulate array for 1.58-bit (ternary) weights times signed activations.
- Each cycle, one ternary weight per row and one signed activation per column are applied to every accumulator cell.
- The block snapshots the accumulators into a double-buffered output queue and streams them out as post-processed signed bytes under a valid/ready handshake.
- It sits between the packed-weight/activation input pins and the 8-bit result output.

Parameters:
ROWS, 4, number of weight rows (ternary lanes)
COLS, 2, number of activation columns
IN_W, 8, signed activation width
ACC_W, 17, signed accumulator width (two's complement, wraps on overflow)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  weights/activations valid this cycle
in_weights  input  2*ROWS  packed ternary weights, row r at bits [2r+1:2r]
in_acts  input  COLS*IN_W  signed activations, column c at bits [c*IN_W +: IN_W]
read_start  input  1  pulse: snapshot accumulators, clear them, start readout
shift  input  4  arithmetic right-shift applied on readout, sampled at read_start
relu  input  1  clamp negative results to 0 on readout, sampled at read_start
out_data  output  8  post-processed signed result
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data
out_last  output  1  marks final element of a readout
read_busy  output  1  readout in progress

Behaviour:
- Weight decode: 00 -> 0, 01 -> +1, 10 -> -1, 11 -> -1.
- Input stage: in_valid, in_weights, in_acts and read_start are registered, giving a 1-cycle pipeline.
  - At the next edge, cell (r,c) computes acc_next = acc + w[r]*sext(x[c]) if the registered valid is set, else acc_next = acc.
- Snapshot: when the registered read_start is set and the block is in IDLE:
  - queue[r*COLS+c] <= acc_next, so the sample presented in the same cycle as read_start is included;
  - every acc <= 0;
  - shift and relu are latched;
  - FSM enters STREAM.
- Latency: read_start in cycle t -> first out_valid in cycle t+2.
- FSM states:
  - IDLE: out_valid=0, read_busy=0.
  - STREAM: out_valid=1, read_busy=1, idx starts at 0. On out_valid & out_ready, idx increments.
  - Leaving STREAM: when idx==ROWS*COLS-1 and out_ready is high, return to IDLE.
- Order and last flag: readout is row-major, idx = r*COLS+c. out_last=1 only when idx==ROWS*COLS-1.
- Post-processing of queue[idx]:
  - v = relu_l ? max(q,0) : q;
  - v = v >>> shift_l;
  - saturate v to [-128,127], giving out_data.
- Stall: out_data, out_valid and idx hold while out_ready=0.
- Accumulation continues during STREAM because the accumulators and the queue are separate buffers.
- read_start during STREAM is ignored: no snapshot and no clear.
- Overflow: accumulators wrap modulo 2^ACC_W; no flag is raised.
- Reset, including mid-readout:
  - all accumulators, queue entries and the input stage registers clear to 0;
  - idx=0, FSM goes to IDLE;
  - out_valid=0, out_last=0, read_busy=0, out_data=0.
- Simultaneous reset and read_start: reset wins.

Optional Feature:
- Macro: TERNARY_MAC_ROUND_EN.
- Defined: when shift_l>0, 1<<(shift_l-1) is added to v after relu and before the shift (round half up). The add is done in ACC_W+1 bits to avoid wrap.
- Undefined: plain truncating arithmetic shift.

Test Plan:
- Reset, then ROWS=4, COLS=2: 3 valid cycles with weights {+1,-1,0,+1} and acts {10,-3}, then read_start with shift=0 -> 8 outputs in order 30,-9,-30,9,0,0,30,-9; out_last on the 8th.
- Accumulate 100 cycles of w=+1, x=100 (sum 10000), read_start with shift=6 -> 127 (saturated). Same with shift=8 -> 39; with TERNARY_MAC_ROUND_EN -> 39 (10000/256=39.06).
- Accumulate -500 in a cell, read_start with relu=1, shift=0 -> 0. With relu=0, shift=2 -> -125.
- out_ready held low for 5 cycles mid-stream -> out_data, out_valid and idx stable. Extra read_start during STREAM ignored. Accumulation of new inputs during STREAM appears in the next readout.
- Sample with in_valid=1 in the same cycle as read_start is included in the snapshot. The following readout starts from 0 (all zeros if no new inputs).
- Assert reset at idx=3 of a stream -> next cycle out_valid=0, read_busy=0. A fresh read_start afterwards yields all zeros.
